// File: rtl/binary_image_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : binary_image_packer_if
// Description : Pixel-in / packed-word-out stream bundle for the binary image
//               packer. The slave modport is the packer's view; the master
//               modport is the view of whatever feeds and drains it.
// Revision    : 1.0 - initial release
// ============================================================================
interface binary_image_packer_if #(
    parameter int WORD_W = 32
);
    // Pixel stream (upstream -> packer)
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_data;
    logic              invert;

    // Packed word stream (packer -> downstream)
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_eol;
    logic              out_eof;

    // Frame status
    logic              frame_done;
    logic              busy;

    modport master (
        output pix_valid,
        output pix_data,
        output invert,
        output out_ready,
        input  pix_ready,
        input  out_valid,
        input  out_data,
        input  out_eol,
        input  out_eof,
        input  frame_done,
        input  busy
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  invert,
        input  out_ready,
        output pix_ready,
        output out_valid,
        output out_data,
        output out_eol,
        output out_eof,
        output frame_done,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/binary_image_packer.sv
`default_nettype none
// ============================================================================
// Module      : binary_image_packer
// Description : Packs a raster-order stream of 1-bit pixels into WORD_W-bit
//               words. A word closes when it is full or when the row ends;
//               rows never share a word and row-end padding is zero. The
//               pixel polarity is latched once per frame at row 0 col 0.
//               The output word is a single register stage with
//               valid/ready flow control; pixel intake stalls only while a
//               word is held back by the downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_image_packer #(
    parameter int IMG_W     = 1920,
    parameter int IMG_H     = 1080,
    parameter int WORD_W    = 32,
    parameter int MSB_FIRST = 1
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    binary_image_packer_if.slave bus
);

    // ------------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------------
    localparam int C_COL_W  = (IMG_W  > 1) ? $clog2(IMG_W)  : 1;
    localparam int C_ROW_W  = (IMG_H  > 1) ? $clog2(IMG_H)  : 1;
    localparam int C_FILL_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [C_COL_W-1:0]  C_COL_LAST  = C_COL_W'(IMG_W - 1);
    localparam logic [C_ROW_W-1:0]  C_ROW_LAST  = C_ROW_W'(IMG_H - 1);
    localparam logic [C_FILL_W-1:0] C_FILL_LAST = C_FILL_W'(WORD_W - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [C_COL_W-1:0]  col_q,  col_d;
    logic [C_ROW_W-1:0]  row_q,  row_d;
    logic [C_FILL_W-1:0] fill_q, fill_d;
    logic                inv_q,  inv_d;
    logic [WORD_W-1:0]   acc_q,  acc_d;

    logic                out_valid_q,  out_valid_d;
    logic [WORD_W-1:0]   out_data_q,   out_data_d;
    logic                out_eol_q,    out_eol_d;
    logic                out_eof_q,    out_eof_d;
    logic                frame_done_q, frame_done_d;
    logic                busy_q,       busy_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                w_pix_ready;
    logic                w_accept;
    logic                w_out_fire;
    logic                w_frame_start;
    logic                w_inv_eff;
    logic                w_bit;
    logic                w_col_last;
    logic                w_row_last;
    logic                w_fill_last;
    logic                w_close;
    logic [C_FILL_W-1:0] w_bit_idx;
    logic [WORD_W-1:0]   w_bit_mask;
    logic [WORD_W-1:0]   w_word;

    // Intake stalls only while a finished word is held back downstream;
    // this depends on the output register and out_ready, never on pix_valid.
    assign w_pix_ready   = !(out_valid_q && !bus.out_ready);
    assign w_accept      = bus.pix_valid && w_pix_ready;
    assign w_out_fire    = out_valid_q && bus.out_ready;

    assign w_col_last    = (col_q  == C_COL_LAST);
    assign w_row_last    = (row_q  == C_ROW_LAST);
    assign w_fill_last   = (fill_q == C_FILL_LAST);
    assign w_frame_start = (col_q == '0) && (row_q == '0);

    // The first pixel of a frame already uses the freshly sampled polarity.
    assign w_inv_eff     = w_frame_start ? bus.invert : inv_q;
    assign w_bit         = bus.pix_data ^ w_inv_eff;

    // A word closes when full or at the end of a row, whichever is first.
    assign w_close       = w_accept && (w_fill_last || w_col_last);

    // Bit position of the current pixel within the word being assembled.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_bit_idx = C_FILL_LAST - fill_q;
        end else begin : g_lsb_first
            assign w_bit_idx = fill_q;
        end
    endgenerate

    // Unwritten positions stay zero because the accumulator is cleared on
    // every close, so row-end padding is never affected by polarity.
    assign w_bit_mask = WORD_W'(w_bit) << w_bit_idx;
    assign w_word     = acc_q | w_bit_mask;

    // Next-state computation for counters, accumulator and output stage
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        fill_d       = fill_q;
        inv_d        = inv_q;
        acc_d        = acc_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_eol_d    = out_eol_q;
        out_eof_d    = out_eof_q;
        frame_done_d = 1'b0;
        busy_d       = busy_q;

        if (w_accept) begin
            inv_d = w_inv_eff;

            if (w_close) begin
                acc_d  = '0;
                fill_d = '0;
            end else begin
                acc_d  = w_word;
                fill_d = fill_q + 1'b1;
            end

            if (w_col_last) begin
                col_d = '0;
                row_d = w_row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // A closing word either fills an empty register or replaces one that
        // is leaving this very cycle; a held word blocks intake, so no overwrite.
        if (w_close) begin
            out_valid_d = 1'b1;
            out_data_d  = w_word;
            out_eol_d   = w_col_last;
            out_eof_d   = w_col_last && w_row_last;
        end else if (w_out_fire) begin
            out_valid_d = 1'b0;
        end

        frame_done_d = w_out_fire && out_eof_q;

        // A pixel of the next frame arriving alongside the eof handshake
        // keeps busy asserted without a gap.
        if (w_accept) begin
            busy_d = 1'b1;
        end else if (w_out_fire && out_eof_q) begin
            busy_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            fill_q       <= '0;
            inv_q        <= 1'b0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_eol_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            fill_q       <= fill_d;
            inv_q        <= inv_d;
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_eol_q    <= out_eol_d;
            out_eof_q    <= out_eof_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.pix_ready  = w_pix_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_eol    = out_eol_q;
    assign bus.out_eof    = out_eof_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_binary_image_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_binary_image_packer
// Description : Directed self-checking bench for binary_image_packer. Three
//               instances cover MSB-first 10x2, LSB-first 10x2 and a 16x1
//               frame for polarity latching. Expected words are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_binary_image_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    binary_image_packer_if #(.WORD_W(8)) if_a ();
    binary_image_packer_if #(.WORD_W(8)) if_b ();
    binary_image_packer_if #(.WORD_W(8)) if_c ();

    binary_image_packer #(.IMG_W(10), .IMG_H(2), .WORD_W(8), .MSB_FIRST(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    binary_image_packer #(.IMG_W(10), .IMG_H(2), .WORD_W(8), .MSB_FIRST(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    binary_image_packer #(.IMG_W(16), .IMG_H(1), .WORD_W(8), .MSB_FIRST(1)) u_dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_c)
    );

    int total = 0;
    int bad   = 0;

    // Recorded handshaken words: {eof, eol, data}
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];
    logic [9:0] q_c[$];
    int fd_a = 0;
    int fd_b = 0;
    int fd_c = 0;

    // Busy continuity watch for the back-to-back frames on instance A
    logic mon_en    = 1'b0;
    logic mon_done  = 1'b0;
    int   mon_drops = 0;
    int   mon_eofs  = 0;

    // Frame pattern for instance A: 20 pixels, raster order
    logic pat [20] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Output monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (if_a.out_valid && if_a.out_ready) q_a.push_back({if_a.out_eof, if_a.out_eol, if_a.out_data});
        if (if_b.out_valid && if_b.out_ready) q_b.push_back({if_b.out_eof, if_b.out_eol, if_b.out_data});
        if (if_c.out_valid && if_c.out_ready) q_c.push_back({if_c.out_eof, if_c.out_eol, if_c.out_data});
        if (if_a.frame_done) fd_a++;
        if (if_b.frame_done) fd_b++;
        if (if_c.frame_done) fd_c++;
        if (mon_en && !mon_done) begin
            if (!if_a.busy) mon_drops++;
            if (if_a.out_valid && if_a.out_ready && if_a.out_eof) begin
                mon_eofs++;
                if (mon_eofs == 2) mon_done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one pixel to instance d and hold it until accepted (bounded)
    task automatic send_px(input int d, input logic data, input logic inv);
        logic rdy;
        logic got;
        got = 1'b0;
        case (d)
            0: begin if_a.pix_valid = 1'b1; if_a.pix_data = data; if_a.invert = inv; end
            1: begin if_b.pix_valid = 1'b1; if_b.pix_data = data; if_b.invert = inv; end
            default: begin if_c.pix_valid = 1'b1; if_c.pix_data = data; if_c.invert = inv; end
        endcase
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            case (d)
                0: rdy = if_a.pix_ready;
                1: rdy = if_b.pix_ready;
                default: rdy = if_c.pix_ready;
            endcase
            @(posedge clk);
            #1;
            got = rdy;
        end
        case (d)
            0: if_a.pix_valid = 1'b0;
            1: if_b.pix_valid = 1'b0;
            default: if_c.pix_valid = 1'b0;
        endcase
        chk("px_accept", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_fd(input int d, input int target);
        int cur;
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(posedge clk);
            #1;
            cur = (d == 0) ? fd_a : (d == 1) ? fd_b : fd_c;
            ok = (cur >= target);
        end
        chk("frame_done_wait", {31'd0, ok}, 32'd1);
        cyc(4);
    endtask

    task automatic chk_word(input int d, input int idx, input logic [9:0] exp, input string tag);
        logic [9:0] obs;
        obs = 'x;
        case (d)
            0: if (idx < q_a.size()) obs = q_a[idx];
            1: if (idx < q_b.size()) obs = q_b[idx];
            default: if (idx < q_c.size()) obs = q_c[idx];
        endcase
        chk(tag, {22'd0, obs}, {22'd0, exp});
    endtask

    int ba, fa;

    initial begin
        if_a.pix_valid = 1'b0; if_a.pix_data = 1'b0; if_a.invert = 1'b0; if_a.out_ready = 1'b1;
        if_b.pix_valid = 1'b0; if_b.pix_data = 1'b0; if_b.invert = 1'b0; if_b.out_ready = 1'b1;
        if_c.pix_valid = 1'b0; if_c.pix_data = 1'b0; if_c.invert = 1'b0; if_c.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid",  {31'd0, if_a.out_valid},  32'd0);
        chk("rst_out_data",   {24'd0, if_a.out_data},   32'd0);
        chk("rst_out_eol",    {31'd0, if_a.out_eol},    32'd0);
        chk("rst_out_eof",    {31'd0, if_a.out_eof},    32'd0);
        chk("rst_frame_done", {31'd0, if_a.frame_done}, 32'd0);
        chk("rst_busy",       {31'd0, if_a.busy},       32'd0);
        chk("rst_pix_ready",  {31'd0, if_a.pix_ready},  32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_pix_ready", {31'd0, if_a.pix_ready}, 32'd1);
        @(posedge clk);
        #1;

        // All-ones frame, MSB first: FF, C0(eol), FF, C0(eol,eof)
        ba = q_a.size(); fa = fd_a;
        for (int i = 0; i < 20; i++) begin
            send_px(0, 1'b1, 1'b0);
            if (i == 7) begin
                @(negedge clk);
                chk("latency_valid", {31'd0, if_a.out_valid}, 32'd1);
                chk("latency_data",  {24'd0, if_a.out_data},  32'h0000_00FF);
                @(posedge clk);
                #1;
            end
        end
        wait_fd(0, fa + 1);
        chk("ones_count", q_a.size() - ba, 32'd4);
        chk_word(0, ba + 0, 10'h0FF, "ones_w0");
        chk_word(0, ba + 1, 10'h1C0, "ones_w1");
        chk_word(0, ba + 2, 10'h0FF, "ones_w2");
        chk_word(0, ba + 3, 10'h3C0, "ones_w3");
        chk("ones_frame_done", fd_a - fa, 32'd1);
        chk("ones_busy_idle", {31'd0, if_a.busy}, 32'd0);

        // LSB first, alternating 1,0: 55, 01(eol) per row
        ba = q_b.size(); fa = fd_b;
        for (int i = 0; i < 20; i++) send_px(1, ((i % 2) == 0), 1'b0);
        wait_fd(1, fa + 1);
        chk("lsb_count", q_b.size() - ba, 32'd4);
        chk_word(1, ba + 0, 10'h055, "lsb_w0");
        chk_word(1, ba + 1, 10'h101, "lsb_w1");
        chk_word(1, ba + 2, 10'h055, "lsb_w2");
        chk_word(1, ba + 3, 10'h301, "lsb_w3");

        // Polarity latched at first pixel; mid-frame toggle ignored
        ba = q_c.size(); fa = fd_c;
        for (int i = 0; i < 16; i++) send_px(2, 1'b0, (i < 8));
        wait_fd(2, fa + 1);
        chk("inv_count", q_c.size() - ba, 32'd2);
        chk_word(2, ba + 0, 10'h0FF, "inv_w0");
        chk_word(2, ba + 1, 10'h3FF, "inv_w1");
        // Next frame re-latches polarity (0), later toggle to 1 ignored
        ba = q_c.size(); fa = fd_c;
        for (int i = 0; i < 16; i++) send_px(2, 1'b0, (i >= 4));
        wait_fd(2, fa + 1);
        chk("relatch_count", q_c.size() - ba, 32'd2);
        chk_word(2, ba + 0, 10'h000, "relatch_w0");
        chk_word(2, ba + 1, 10'h300, "relatch_w1");

        // Downstream stall: B2 held 5 cycles, no pixel lost
        ba = q_a.size(); fa = fd_a;
        if_a.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_px(0, pat[i], 1'b0);
        if_a.pix_valid = 1'b1;
        if_a.pix_data  = pat[8];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_pix_ready", {31'd0, if_a.pix_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, if_a.out_valid}, 32'd1);
            chk("stall_out_data",  {24'd0, if_a.out_data},  32'h0000_00B2);
            @(posedge clk);
            #1;
        end
        if_a.out_ready = 1'b1;
        for (int i = 8; i < 20; i++) send_px(0, pat[i], 1'b0);
        wait_fd(0, fa + 1);
        chk("stall_count", q_a.size() - ba, 32'd4);
        chk_word(0, ba + 0, 10'h0B2, "stall_w0");
        chk_word(0, ba + 1, 10'h1C0, "stall_w1");
        chk_word(0, ba + 2, 10'h069, "stall_w2");
        chk_word(0, ba + 3, 10'h340, "stall_w3");

        // Reset after 13 pixels, then a clean frame
        ba = q_a.size();
        for (int i = 0; i < 13; i++) send_px(0, 1'b1, 1'b0);
        cyc(3);
        chk("pre_rst_count", q_a.size() - ba, 32'd2);
        chk_word(0, ba + 0, 10'h0FF, "pre_rst_w0");
        chk_word(0, ba + 1, 10'h1C0, "pre_rst_w1");
        rst_n = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, if_a.out_valid}, 32'd0);
        chk("midrst_busy",      {31'd0, if_a.busy},      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ba = q_a.size(); fa = fd_a;
        for (int i = 0; i < 20; i++) send_px(0, pat[i], 1'b0);
        wait_fd(0, fa + 1);
        chk("postrst_count", q_a.size() - ba, 32'd4);
        chk_word(0, ba + 0, 10'h0B2, "postrst_w0");
        chk_word(0, ba + 1, 10'h1C0, "postrst_w1");
        chk_word(0, ba + 2, 10'h069, "postrst_w2");
        chk_word(0, ba + 3, 10'h340, "postrst_w3");
        chk("postrst_frame_done", fd_a - fa, 32'd1);

        // Two frames back-to-back, busy continuous
        ba = q_a.size(); fa = fd_a;
        send_px(0, 1'b1, 1'b0);
        mon_en = 1'b1;
        for (int i = 1; i < 40; i++) send_px(0, 1'b1, 1'b0);
        wait_fd(0, fa + 2);
        chk("b2b_count", q_a.size() - ba, 32'd8);
        for (int f = 0; f < 2; f++) begin
            chk_word(0, ba + 4 * f + 0, 10'h0FF, "b2b_w0");
            chk_word(0, ba + 4 * f + 1, 10'h1C0, "b2b_w1");
            chk_word(0, ba + 4 * f + 2, 10'h0FF, "b2b_w2");
            chk_word(0, ba + 4 * f + 3, 10'h3C0, "b2b_w3");
        end
        chk("b2b_frame_done", fd_a - fa, 32'd2);
        chk("b2b_busy_drops", mon_drops, 32'd0);
        chk("b2b_eofs_seen", {31'd0, mon_done}, 32'd1);
        chk("b2b_busy_idle", {31'd0, if_a.busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
